// File: rtl/i2c_bus_frontend.sv
// I2C pin conditioning: per-line synchroniser + deglitch filter, edge/START/STOP events, bus-busy tracking.
// Optional SCL-low bus timeout is compiled in when I2C_TIMEOUT_EN is defined.
module i2c_bus_frontend #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILT_LEN       = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clock,
    input  logic reset,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic scl_filt,
    output logic sda_filt,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic bus_timeout
);
    localparam int CW = $clog2(FILT_LEN + 1);

    if (SYNC_STAGES < 2 || FILT_LEN < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("i2c_bus_frontend: illegal parameter value");
    end

    // Index 0 is SCL, index 1 is SDA.
    logic [1:0] pin_w;
    logic [1:0] filt_w;

    assign pin_w = {sda_pin, scl_pin};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic [CW-1:0]          cnt_q, cnt_d;
            logic                   filt_q, filt_d;
            logic                   sync_last;

            assign sync_last = sync_q[SYNC_STAGES-1];

            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], pin_w[gi]};
                filt_d = filt_q;
                cnt_d  = '0;
                // Any return to the accepted level drops the count back to zero.
                if (sync_last != filt_q) begin
                    if (cnt_q == CW'(FILT_LEN - 1)) begin
                        filt_d = sync_last;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sync_q <= '1;
                    cnt_q  <= '0;
                    filt_q <= 1'b1;
                end else begin
                    sync_q <= sync_d;
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign filt_w[gi] = filt_q;
        end
    endgenerate

    assign scl_filt = filt_w[0];
    assign sda_filt = filt_w[1];

    logic scl_q, scl_d;
    logic sda_q, sda_d;
    logic busy_q, busy_d;
    logic timeout_w;

    assign scl_d = scl_filt;
    assign sda_d = sda_filt;

    assign scl_rise  = scl_filt & ~scl_q;
    assign scl_fall  = ~scl_filt & scl_q;
    // Requiring SCL stable across both cycles rejects simultaneous SCL/SDA changes.
    assign start_det = ~sda_filt & sda_q & scl_filt & scl_q;
    assign stop_det  = sda_filt & ~sda_q & scl_filt & scl_q;

`ifdef I2C_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] to_cnt_q, to_cnt_d;

    assign timeout_w = busy_q & ~scl_filt & (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (!busy_q || scl_filt) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TW'(TIMEOUT_CYCLES - 1)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_w = 1'b0;
`endif

    always_comb begin
        busy_d = busy_q;
        if (start_det) begin
            busy_d = 1'b1;
        end else if (stop_det || timeout_w) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            scl_q  <= scl_d;
            sda_q  <= sda_d;
            busy_q <= busy_d;
        end
    end

    assign bus_busy    = busy_q;
    assign bus_timeout = timeout_w;

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Directed bench for i2c_bus_frontend: a window-based line model checked every cycle plus literal event checks.
// Build with I2C_TIMEOUT_EN defined to exercise the timeout path.
module tb_i2c_bus_frontend;
    localparam int SYNC_STAGES    = 2;
    localparam int FILT_LEN       = 4;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int HL             = SYNC_STAGES + FILT_LEN;
`ifdef I2C_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic scl_pin = 1'b1;
    logic sda_pin = 1'b1;
    logic scl_filt, sda_filt, scl_rise, scl_fall, start_det, stop_det, bus_busy, bus_timeout;

    int total = 0;
    int bad = 0;
    int n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0, n_to = 0;

    i2c_bus_frontend #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN(FILT_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset_n),
        .scl_pin(scl_pin),
        .sda_pin(sda_pin),
        .scl_filt(scl_filt),
        .sda_filt(sda_filt),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start_det(start_det),
        .stop_det(stop_det),
        .bus_busy(bus_busy),
        .bus_timeout(bus_timeout)
    );

    always #5 clock = ~clock;

    // Model: a line's filtered level flips to x once FILT_LEN consecutive pin samples,
    // delayed by the synchroniser depth, all read x.
    logic [HL-1:0] scl_h, sda_h;
    bit m_scl, m_sda, m_scl_p, m_sda_p, m_busy;
    int m_low;

    function automatic bit m_start();
        return !m_sda && m_sda_p && m_scl && m_scl_p;
    endfunction
    function automatic bit m_stop();
        return m_sda && !m_sda_p && m_scl && m_scl_p;
    endfunction
    function automatic bit m_to();
        return TO_EN && m_busy && !m_scl && (m_low == TIMEOUT_CYCLES - 1);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_h = '1; sda_h = '1;
            m_scl = 1; m_sda = 1; m_scl_p = 1; m_sda_p = 1;
            m_busy = 0; m_low = 0;
        end else begin
            bit st, sp, to;
            logic [FILT_LEN-1:0] w;
            st = m_start(); sp = m_stop(); to = m_to();
            if (m_busy && !m_scl) begin
                if (m_low != TIMEOUT_CYCLES - 1) m_low = m_low + 1;
            end else begin
                m_low = 0;
            end
            if (st) m_busy = 1;
            else if (sp || to) m_busy = 0;
            m_scl_p = m_scl;
            m_sda_p = m_sda;
            scl_h = {scl_h[HL-2:0], scl_pin};
            sda_h = {sda_h[HL-2:0], sda_pin};
            w = scl_h[HL-1:SYNC_STAGES];
            if (&w) m_scl = 1; else if (~|w) m_scl = 0;
            w = sda_h[HL-1:SYNC_STAGES];
            if (&w) m_sda = 1; else if (~|w) m_sda = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("scl_filt", int'(scl_filt), int'(m_scl));
        check("sda_filt", int'(sda_filt), int'(m_sda));
        check("scl_rise", int'(scl_rise), int'(m_scl && !m_scl_p));
        check("scl_fall", int'(scl_fall), int'(!m_scl && m_scl_p));
        check("start_det", int'(start_det), int'(m_start()));
        check("stop_det", int'(stop_det), int'(m_stop()));
        check("bus_busy", int'(bus_busy), int'(m_busy));
        check("bus_timeout", int'(bus_timeout), int'(m_to()));
        n_rise  += int'(scl_rise === 1'b1);
        n_fall  += int'(scl_fall === 1'b1);
        n_start += int'(start_det === 1'b1);
        n_stop  += int'(stop_det === 1'b1);
        n_to    += int'(bus_timeout === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clr();
        n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0; n_to = 0;
    endtask

    initial begin
        logic [8:0] bits;
        bits = 9'b1010_0101_0;

        tick(3);
        reset_n = 1'b1;
        clr();
        tick(100);
        check("idle_pulses", n_rise + n_fall + n_start + n_stop + n_to, 0);
        check("idle_busy", int'(bus_busy), 0);
        check("idle_scl", int'(scl_filt), 1);
        $display("idle: 100 cycles");

        sda_pin = 1'b0; tick(3); sda_pin = 1'b1;
        clr();
        tick(20);
        check("glitch_start", n_start, 0);
        check("glitch_sda", int'(sda_filt), 1);
        $display("glitch: 3-cycle SDA low");

        sda_pin = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("start_edge", int'(start_det), int'(i == 6));
        end
        tick(1);
        check("busy_after_start", int'(bus_busy), 1);
        $display("start: SDA low with SCL high");

        scl_pin = 1'b0; tick(10);
        clr();
        for (int b = 8; b >= 0; b--) begin
            sda_pin = bits[b]; tick(10);
            scl_pin = 1'b1; tick(20);
            scl_pin = 1'b0; tick(10);
        end
        check("byte_rise", n_rise, 9);
        check("byte_fall", n_fall, 9);
        clr();
        sda_pin = 1'b0; tick(10);
        scl_pin = 1'b1; tick(20);
        sda_pin = 1'b1; tick(20);
        check("stop_count", n_stop, 1);
        check("busy_after_stop", int'(bus_busy), 0);
        $display("byte: 0xA5 + ack, then STOP");

        clr();
        scl_pin = 1'b0; sda_pin = 1'b0; tick(20);
        check("simul_fall", n_fall, 1);
        check("simul_start", n_start, 0);
        scl_pin = 1'b1; tick(20);
        sda_pin = 1'b1; tick(20);
        check("idle_stop_busy", int'(bus_busy), 0);
        $display("simultaneous: SCL/SDA fall together, idle STOP");

        sda_pin = 1'b0; tick(20);
        scl_pin = 1'b0; tick(20);
        sda_pin = 1'b1; tick(10);
        scl_pin = 1'b1; tick(20);
        clr();
        sda_pin = 1'b0; tick(20);
        check("rstart_count", n_start, 1);
        check("rstart_busy", int'(bus_busy), 1);
        $display("repeated start while busy");

        scl_pin = 1'b0; tick(20);
        reset_n = 1'b0;
        #1;
        check("rst_scl", int'(scl_filt), 1);
        check("rst_busy", int'(bus_busy), 0);
        check("rst_fall", int'(scl_fall), 0);
        tick(3);
        sda_pin = 1'b1;
        reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("rst_release_fall", int'(scl_fall), int'(i == 6));
        end
        $display("reset mid-byte, release with SCL low");

        scl_pin = 1'b1; tick(20);
        sda_pin = 1'b0; tick(20);
        clr();
        scl_pin = 1'b0; tick(100);
        check("timeout_count", n_to, TO_EN ? 1 : 0);
        check("timeout_busy", int'(bus_busy), TO_EN ? 0 : 1);
        scl_pin = 1'b1; tick(20);
        sda_pin = 1'b1; tick(20);
        $display("timeout: SCL held low while busy");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
